imem_program_controller: RTL and testbench
==========================================

Name: imem_program_controller

Overview:
- Sequences and owns the 256x16 instruction memory of the 8-bit CPU. The memory has an 8-bit address and a 16-bit word.
- In RUN mode it passes CPU fetches straight through to the memory.
- In LOAD mode it holds the CPU in reset and accepts a byte stream from the host loader (UART receiver side). It assembles 16-bit words, writes them sequentially from address 0x00, and zero-fills the unused tail so unprogrammed locations read 16'h0000.
- When the load completes it releases the CPU so execution starts at address 0x00.

Parameters:
- TIMEOUT, default 65535: maximum idle cycles between accepted loader bytes before the load aborts. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  8  CPU fetch address
- cpu_data  out  16  instruction word returned to the CPU
- cpu_reset  out  1  holds the CPU in reset
- mem_addr  out  8  instruction memory address
- mem_wdata  out  16  instruction memory write data
- mem_we  out  1  instruction memory write enable
- mem_rdata  in  16  instruction memory read data (asynchronous read)
- ld_start  in  1  single-cycle request to begin a load
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte
- ld_ready  out  1  controller can accept a byte
- busy  out  1  load in progress
- load_err  out  1  last load aborted on timeout (sticky)

Behaviour:
- Reset values and state on reset:
  - State RUN.
  - cpu_reset=0, mem_we=0, ld_ready=0, busy=0, load_err=0.
  - Word count, write pointer, hi-byte register and timeout counter cleared.
  - Reset asserted mid-load aborts the load immediately. Memory keeps whatever was already written.
- Stream format:
  - Byte 0 is the word count N. N=0 means 256.
  - Then 2N bytes follow, each word sent high byte first, then low byte.
- Byte acceptance: a byte is accepted on any clk edge where ld_valid && ld_ready.
- RUN:
  - mem_addr=cpu_addr and cpu_data=mem_rdata, both combinational.
  - mem_we=0, ld_ready=0.
  - ld_start=1 moves to GET_COUNT next cycle.
- All states other than RUN:
  - cpu_reset=1 and busy=1.
  - cpu_data=16'h0000 (NOP).
  - mem_addr=write pointer.
- GET_COUNT:
  - ld_ready=1.
  - On an accepted byte: store N, clear the write pointer and load_err, go to GET_HI.
- GET_HI:
  - ld_ready=1.
  - On an accepted byte: latch the high byte, go to GET_LO.
- GET_LO:
  - ld_ready=1.
  - On an accepted byte: form {hi, ld_byte}, go to WRITE.
- WRITE:
  - Exactly one cycle with mem_we=1 and mem_wdata = the assembled word at the write pointer.
  - If pointer == N-1: with N=256 go to RELEASE; otherwise increment the pointer and go to CLEAR.
  - Otherwise increment the pointer and go to GET_HI.
- CLEAR:
  - mem_we=1 and mem_wdata=0 each cycle while the pointer increments.
  - After writing 0xFF go to RELEASE.
  - Takes 256-N cycles.
- RELEASE:
  - One cycle with cpu_reset=1 and mem_we=0, then RUN.
  - cpu_reset therefore falls on the clock edge that enters RUN.
- Timeout:
  - The counter runs only in GET_* states. It clears on every accepted byte and on entering GET_COUNT.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: go to ERROR and set load_err=1.
- ERROR:
  - cpu_reset=1, busy=0, ld_ready=0, mem_we=0.
  - Only ld_start (to GET_COUNT) or reset leaves this state.
  - The CPU is never released with a partial program.
- ld_start outside RUN and ERROR is ignored.
- ld_valid while ld_ready=0 is ignored; the byte is dropped with no side effects.
- Pointer arithmetic: the pointer is 8 bits plus a terminal check. It never wraps into address 0 during CLEAR.
- Latency: from the final low byte accepted to cpu_reset falling is 1 (WRITE) + (256-N) (CLEAR) + 1 (RELEASE) cycles.

Decomposition:
- Shared package imem_ctrl_pkg contains:
  - state enum (RUN, GET_COUNT, GET_HI, GET_LO, WRITE, CLEAR, RELEASE, ERROR)
  - IMEM_DEPTH=256, IMEM_AW=8, IMEM_DW=16
  - NOP_WORD=16'h0000
- One sub-module, imem_ld_timeout: the idle-cycle counter, with clear/enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
- RUN passthrough: preload mem[0x05]=16'h4802, drive cpu_addr=0x05 -> cpu_data=16'h4802 in the same cycle, with mem_we=0 and cpu_reset=0.
- Short load: ld_start, then stream 0x03,4A,0A,4E,02,48,00 -> mem[0..2] = 4A0A, 4E02, 4800; mem[3..FF] = 0000; exactly 256 mem_we cycles. cpu_reset falls 255 cycles after the last byte is accepted, and busy falls with it.
- Full load with N=0: 512 data bytes with word i = {i, ~i} -> no CLEAR cycles; cpu_reset falls 2 cycles after the last byte; mem[0xFF]=16'hFF00.
- Backpressure/gaps: random ld_valid gaps shorter than TIMEOUT, plus ld_valid pulses while in RUN -> identical memory image; no writes in RUN.
- Timeout: with TIMEOUT=16, stop after the high byte of word 1 -> ERROR after 16 idle cycles, load_err=1, cpu_reset stays 1, mem[1] unwritten. A subsequent ld_start and full stream recovers, load_err clears, and the CPU is released.
- Reset mid-CLEAR: assert reset -> next cycle state RUN, cpu_reset=0, mem_we=0, busy=0; a later ld_start proceeds normally.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory program controller.
package imem_ctrl_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DW    = 16;

  localparam logic [IMEM_DW-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_GET_COUNT,
    ST_GET_HI,
    ST_GET_LO,
    ST_WRITE,
    ST_CLEAR,
    ST_RELEASE,
    ST_ERROR
  } imem_state_e;

endpackage

// File: rtl/imem_ld_timeout.sv
// Idle-cycle watchdog for the loader byte stream; expired fires on the idle
// cycle that would take the count to TIMEOUT (TIMEOUT=0 disables it).
module imem_ld_timeout #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && en && !clr && (cnt == LAST);

endmodule

// File: rtl/imem_program_controller.sv
// Owns the 256x16 instruction memory: CPU fetch passthrough in RUN, and a
// byte-stream loader that writes, zero-fills the tail, then releases the CPU.
module imem_program_controller
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IMEM_AW-1:0] cpu_addr,
  output logic [IMEM_DW-1:0] cpu_data,
  output logic               cpu_reset,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [IMEM_DW-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [IMEM_DW-1:0] mem_rdata,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  output logic               ld_ready,
  output logic               busy,
  output logic               load_err
);

  localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

  imem_state_e        state, state_nx;
  logic [IMEM_AW-1:0] wptr, wptr_nx;
  logic [IMEM_AW-1:0] last_ptr, last_nx;
  logic [7:0]         hi_q, hi_nx;
  logic [7:0]         lo_q, lo_nx;
  logic               load_err_nx;
  logic               accept, in_get, tmo;

  assign in_get = (state == ST_GET_COUNT) || (state == ST_GET_HI) || (state == ST_GET_LO);
  assign accept = ld_valid && ld_ready;

  imem_ld_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept || !in_get),
    .en     (in_get),
    .expired(tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      wptr     <= '0;
      last_ptr <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      wptr     <= wptr_nx;
      last_ptr <= last_nx;
      hi_q     <= hi_nx;
      lo_q     <= lo_nx;
      load_err <= load_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wptr_nx     = wptr;
    last_nx     = last_ptr;
    hi_nx       = hi_q;
    lo_nx       = lo_q;
    load_err_nx = load_err;
    cpu_reset   = 1'b1;
    busy        = 1'b1;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    mem_addr    = wptr;
    cpu_data    = NOP_WORD;

    unique case (state)
      ST_RUN: begin
        cpu_reset = 1'b0;
        busy      = 1'b0;
        mem_addr  = cpu_addr;
        cpu_data  = mem_rdata;
        if (ld_start) state_nx = ST_GET_COUNT;
      end
      ST_GET_COUNT: begin
        ld_ready = 1'b1;
        if (accept) begin
          // N=0 wraps to last index 0xFF, which is exactly the 256-word case
          last_nx     = ld_byte - 8'd1;
          wptr_nx     = '0;
          load_err_nx = 1'b0;
          state_nx    = ST_GET_HI;
        end else if (tmo) begin
          load_err_nx = 1'b1;
          state_nx    = ST_ERROR;
        end
      end
      ST_GET_HI: begin
        ld_ready = 1'b1;
        if (accept) begin
          hi_nx    = ld_byte;
          state_nx = ST_GET_LO;
        end else if (tmo) begin
          load_err_nx = 1'b1;
          state_nx    = ST_ERROR;
        end
      end
      ST_GET_LO: begin
        ld_ready = 1'b1;
        if (accept) begin
          lo_nx    = ld_byte;
          state_nx = ST_WRITE;
        end else if (tmo) begin
          load_err_nx = 1'b1;
          state_nx    = ST_ERROR;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = {hi_q, lo_q};
        if (wptr == last_ptr) begin
          if (last_ptr == LAST_ADDR) begin
            state_nx = ST_RELEASE;
          end else begin
            wptr_nx  = wptr + 8'd1;
            state_nx = ST_CLEAR;
          end
        end else begin
          wptr_nx  = wptr + 8'd1;
          state_nx = ST_GET_HI;
        end
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (wptr == LAST_ADDR) state_nx = ST_RELEASE;
        else                   wptr_nx  = wptr + 8'd1;
      end
      ST_RELEASE: begin
        state_nx = ST_RUN;
      end
      ST_ERROR: begin
        busy = 1'b0;
        if (ld_start) state_nx = ST_GET_COUNT;
      end
      default: state_nx = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_imem_program_controller.sv
// Directed/randomized bench for imem_program_controller with a behavioural
// memory stub and a reference image built from the load stream.
module tb_imem_program_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_data;
  logic        cpu_reset;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_ready;
  logic        busy;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_program_controller #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_reset(cpu_reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .busy     (busy),
    .load_err (load_err)
  );

  // Memory stub with a bench-side preload port, plus write counters.
  logic [15:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [15:0] pre_data = 16'h0000;
  int          we_cnt = 0;
  int          run_we = 0;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_we && !cpu_reset) run_we <= run_we + 1;
  end

  assign mem_rdata = mem[mem_addr];

  logic [15:0] words [256];
  logic [15:0] img   [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    repeat (gap) @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    n = 0;
    while (ld_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("ready_wait", {31'b0, ld_ready}, 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_ready", {31'b0, ld_ready}, 32'd1);
    chk("start_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("start_nop", {16'b0, cpu_data}, 32'h0);
  endtask

  // Full load of words[0..n-1]; reference: first n words, rest zero.
  task automatic load_and_check(input int unsigned n, input int unsigned max_gap, input string tag);
    int we0;
    int lat;
    int bad;
    logic [31:0] nn;
    nn  = n;
    we0 = we_cnt;
    start_load();
    send_byte(nn[7:0], $urandom_range(max_gap, 0));
    chk({tag, "_err_clr"}, {31'b0, load_err}, 32'd0);
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(words[i][15:8], $urandom_range(max_gap, 0));
      send_byte(words[i][7:0],  $urandom_range(max_gap, 0));
    end
    lat = 0;
    while (cpu_reset === 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 258 - n);
    chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    for (int unsigned i = 0; i < 256; i++) img[i] = (i < n) ? words[i] : 16'h0000;
    bad = 0;
    for (int unsigned i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
    chk({tag, "_image_mismatches"}, bad, 32'd0);
    chk({tag, "_write_cycles"}, we_cnt - we0, 32'd256);
  endtask

  initial begin
    int r0;
    int w0;
    int bad;
    logic [15:0] t0, t1, keep1, rv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    reset = 1'b0;

    // RUN passthrough
    preload(8'h05, 16'h4802);
    rv = 16'($urandom);
    preload(8'h80, rv);
    cpu_addr = 8'h05;
    #1;
    chk("run_cpu_data", {16'b0, cpu_data}, 32'h4802);
    chk("run_mem_addr", {24'b0, mem_addr}, 32'h05);
    chk("run_mem_we", {31'b0, mem_we}, 32'd0);
    chk("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    @(negedge clk);
    cpu_addr = 8'h80;
    #1;
    chk("run_cpu_data_rand", {16'b0, cpu_data}, {16'b0, rv});

    // Short load
    words[0] = 16'h4A0A; words[1] = 16'h4E02; words[2] = 16'h4800;
    load_and_check(3, 0, "short");
    chk("short_mem0", {16'b0, mem[0]}, 32'h4A0A);
    chk("short_mem2", {16'b0, mem[2]}, 32'h4800);
    chk("short_mem80", {16'b0, mem[8'h80]}, 32'h0000);

    // Full load, N=0 meaning 256 words
    for (int unsigned i = 0; i < 256; i++) begin
      t0 = 16'(i);
      words[i] = {t0[7:0], ~t0[7:0]};
    end
    load_and_check(256, 0, "full");
    chk("full_memFF", {16'b0, mem[8'hFF]}, 32'hFF00);

    // Loader traffic while in RUN must be dropped
    r0 = run_we;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ld_valid = 1'($urandom);
      ld_byte  = 8'($urandom);
      chk("run_pulse_ready", {31'b0, ld_ready}, 32'd0);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    chk("run_pulse_writes", run_we - r0, 32'd0);
    chk("run_pulse_busy", {31'b0, busy}, 32'd0);
    bad = 0;
    for (int unsigned i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
    chk("run_pulse_image", bad, 32'd0);

    // Random loads with idle gaps shorter than TIMEOUT
    for (int rep = 0; rep < 2; rep++) begin
      int unsigned n;
      n = $urandom_range(255, 1);
      for (int unsigned i = 0; i < 256; i++) words[i] = 16'($urandom);
      load_and_check(n, 10, "gaps");
    end

    // Timeout after the high byte of word 1
    keep1 = mem[1];
    t0 = 16'($urandom);
    t1 = 16'($urandom);
    w0 = we_cnt;
    start_load();
    send_byte(8'd4, 0);
    send_byte(t0[15:8], 0);
    send_byte(t0[7:0], 0);
    send_byte(t1[15:8], 0);
    repeat (15) @(negedge clk);
    chk("tmo_busy_before", {31'b0, busy}, 32'd1);
    chk("tmo_err_before", {31'b0, load_err}, 32'd0);
    @(negedge clk);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_load_err", {31'b0, load_err}, 32'd1);
    chk("tmo_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("tmo_ld_ready", {31'b0, ld_ready}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    chk("tmo_hold_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("tmo_hold_err", {31'b0, load_err}, 32'd1);
    chk("tmo_write_count", we_cnt - w0, 32'd1);
    chk("tmo_mem0", {16'b0, mem[0]}, {16'b0, t0});
    chk("tmo_mem1_kept", {16'b0, mem[1]}, {16'b0, keep1});

    // Recovery from ERROR
    for (int unsigned i = 0; i < 256; i++) words[i] = 16'($urandom);
    load_and_check(7, 5, "recover");
    chk("recover_err", {31'b0, load_err}, 32'd0);

    // Reset while zero-filling
    for (int unsigned i = 0; i < 256; i++) words[i] = 16'($urandom);
    start_load();
    send_byte(8'd2, 0);
    for (int unsigned i = 0; i < 2; i++) begin
      send_byte(words[i][15:8], 0);
      send_byte(words[i][7:0], 0);
    end
    repeat (10) @(negedge clk);
    chk("clr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("clr_wdata", {16'b0, mem_wdata}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    load_and_check(5, 3, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
